// File: rtl/cpu_sequencer_pkg.sv
// Shared state encodings and constants for the cpu_sequencer control FSM.
package cpu_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5,
    TRAP   = 3'd7
  } state_t;

  localparam logic [1:0] READ_NO = 2'd0;
  localparam int         TIMER_W = 8;

  // States in which the sequencer stalls waiting on a memory response.
  function automatic logic is_wait_state(input state_t s);
    return (s == FETCH) || (s == MEM);
  endfunction

endpackage

// File: rtl/cpu_sequencer_watchdog.sv
// seq_watchdog: counts consecutive stalled cycles and flags the cycle on which
// the count reaches TIMEOUT_CYCLES. Only instantiated when SEQ_TIMEOUT_EN is defined.
module seq_watchdog
  import cpu_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  localparam logic [TIMER_W-1:0] LIMIT = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] count_reg;

  // count_reg holds the stalled cycles already spent, so the current cycle is
  // the TIMEOUT_CYCLES-th one when it equals LIMIT.
  assign expired = waiting && (count_reg == LIMIT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (waiting && !expired) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB control FSM with sticky TRAP.
// Optional memory-response watchdog enabled by defining SEQ_TIMEOUT_EN.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ifu_rvalid,
  input  logic       lsu_rvalid,
  input  logic       dec_valid,
  input  logic [1:0] dec_mem_read,
  input  logic       dec_mem_write,
  input  logic       dec_reg_write,
  output logic       ifu_req,
  output logic       ir_we,
  output logic       alu_en,
  output logic       lsu_req,
  output logic       lsu_we,
  output logic       rf_we,
  output logic       pc_we,
  output logic       trap,
  output logic [2:0] state
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("cpu_sequencer: TIMEOUT_CYCLES must be within 1..255");
  end

  state_t state_reg, state_next;
  logic   expired;

`ifdef SEQ_TIMEOUT_EN
  logic waiting;

  assign waiting = ((state_reg == FETCH) && !ifu_rvalid) ||
                   ((state_reg == MEM)   && !lsu_rvalid);

  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (!is_wait_state(state_reg)),
    .waiting (waiting),
    .expired (expired)
  );
`else
  assign expired = 1'b0;
`endif

  // A response on the expiry cycle is checked first, so it wins over the trap.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    state_next = FETCH;
      FETCH:   if (ifu_rvalid)   state_next = DECODE;
               else if (expired) state_next = TRAP;
      DECODE:  state_next = dec_valid ? EXEC : TRAP;
      EXEC:    state_next = ((dec_mem_read != READ_NO) || dec_mem_write) ? MEM : WB;
      MEM:     if (lsu_rvalid)   state_next = WB;
               else if (expired) state_next = TRAP;
      WB:      state_next = FETCH;
      TRAP:    state_next = TRAP;
      default: state_next = TRAP;
    endcase
  end

  // Strobes are registered from the next state so they line up with state_reg.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      ifu_req   <= 1'b0;
      alu_en    <= 1'b0;
      lsu_req   <= 1'b0;
      pc_we     <= 1'b0;
      trap      <= 1'b0;
    end else begin
      state_reg <= state_next;
      ifu_req   <= (state_next == FETCH);
      alu_en    <= (state_next == EXEC);
      lsu_req   <= (state_next == MEM);
      pc_we     <= (state_next == WB);
      trap      <= (state_next == TRAP);
    end
  end

  assign ir_we = ifu_req & ifu_rvalid;
  assign lsu_we = lsu_req & dec_mem_write;
  assign rf_we = pc_we & dec_reg_write;
  assign state = state_reg;

endmodule
